// File: rtl/crypt_pkg.sv
// crypt_pkg: FSM state encoding, default feedback taps and zero-seed substitute shared by the LFSR stream cipher
package crypt_pkg;
  typedef enum logic [1:0] {S_UNSEEDED, S_FILL, S_WAIT_IN, S_OUT} state_t;
  localparam logic [15:0] DEF_TAPS = 16'hB400;
  localparam int SEED_MAX_W = 64;
  function automatic logic [SEED_MAX_W-1:0] seed_fix(input logic [SEED_MAX_W-1:0] s);
    return s == '0 ? SEED_MAX_W'(1) : s;
  endfunction
endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: Fibonacci LFSR with seed load (0 mapped to 1) and step enable; ports clk, reset (sync active-low), load, step, seed in; state, key_bit out
module lfsr_core
  import crypt_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] state,
  output logic             key_bit
);
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  always_comb begin
    lfsr_d = load ? WIDTH'(seed_fix(SEED_MAX_W'(seed))) :
             step ? {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)} : lfsr_q;
  end
  always_ff @(posedge clk) begin
    lfsr_q <= reset ? lfsr_d : '0;
  end
  assign state   = lfsr_q;
  assign key_bit = lfsr_q[WIDTH-1];
endmodule

// File: rtl/lfsr_stream_cipher.sv
// lfsr_stream_cipher: LFSR-keystream XOR word cipher; ports clk, reset (sync active-low), en, seed_load/seed, in_valid/in_ready/in_data, out_valid/out_ready/out_data; LFSR_CIPHER_BYPASS_EN adds a bypass input
module lfsr_stream_cipher
  import crypt_pkg::*;
#(
  parameter int               WIDTH  = 16,
  parameter logic [WIDTH-1:0] TAPS   = WIDTH'(DEF_TAPS),
  parameter int               DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              seed_load,
  input  logic [WIDTH-1:0]  seed,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef LFSR_CIPHER_BYPASS_EN
  input  logic              bypass,
`endif
  output logic [DATA_W-1:0] out_data
);
  localparam int CW = $clog2(DATA_W);
  state_t            state_q, state_d;
  logic [CW-1:0]     bitcnt_q, bitcnt_d;
  logic [DATA_W-1:0] keybuf_q, keybuf_d, out_data_q, out_data_d;
  logic              step, key_bit, skip, last;
  logic [WIDTH-1:0]  unused_lfsr;
`ifdef LFSR_CIPHER_BYPASS_EN
  logic skip_q, skip_d;
  assign skip = skip_q;
`else
  assign skip = 1'b0;
`endif
  assign last = bitcnt_q == CW'(DATA_W - 1);
  lfsr_core #(.WIDTH(WIDTH), .TAPS(TAPS)) u_core (
    .clk     (clk),
    .reset   (reset),
    .load    (en && seed_load),
    .step    (step),
    .seed    (seed),
    .state   (unused_lfsr),
    .key_bit (key_bit)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_UNSEEDED;
      bitcnt_q   <= '0;
      keybuf_q   <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      keybuf_q   <= keybuf_d;
      out_data_q <= out_data_d;
    end
  end
`ifdef LFSR_CIPHER_BYPASS_EN
  always_ff @(posedge clk) begin
    skip_q <= reset ? skip_d : 1'b0;
  end
`endif
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    keybuf_d   = keybuf_q;
    out_data_d = out_data_q;
    step       = 1'b0;
`ifdef LFSR_CIPHER_BYPASS_EN
    skip_d     = skip_q;
`endif
    if (en && seed_load) begin
      state_d  = S_FILL;
      bitcnt_d = '0;
`ifdef LFSR_CIPHER_BYPASS_EN
      skip_d   = 1'b0;
`endif
    end else if (en) begin
      case (state_q)
        S_FILL: begin
          step     = !skip;
          keybuf_d = skip ? keybuf_q : {keybuf_q[DATA_W-2:0], key_bit};
          bitcnt_d = last ? '0 : bitcnt_q + 1'b1;
          state_d  = last ? S_WAIT_IN : S_FILL;
`ifdef LFSR_CIPHER_BYPASS_EN
          skip_d   = last ? 1'b0 : skip_q;
`endif
        end
        S_WAIT_IN: if (in_valid) begin
          state_d    = S_OUT;
`ifdef LFSR_CIPHER_BYPASS_EN
          out_data_d = bypass ? in_data : in_data ^ keybuf_q;
          skip_d     = bypass;
`else
          out_data_d = in_data ^ keybuf_q;
`endif
        end
        S_OUT: if (out_ready) begin
          state_d  = S_FILL;
          bitcnt_d = '0;
        end
        default: ;
      endcase
    end
  end
  always_comb begin
    in_ready  = en && state_q == S_WAIT_IN;
    out_valid = state_q == S_OUT;
    out_data  = out_data_q;
  end
endmodule

// File: tb/tb_lfsr_stream_cipher.sv
// tb_lfsr_stream_cipher: directed checks of keystream, latency, stalls, reseed, en freeze and reset
module tb_lfsr_stream_cipher;
  logic        clk = 0, reset = 0, en = 1, seed_load = 0, in_valid = 0, out_ready = 0;
  logic [15:0] seed = '0;
  logic [7:0]  in_data = '0;
  logic        in_ready, out_valid;
  logic [7:0]  out_data;
  int          n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  lfsr_stream_cipher #(.WIDTH(16), .TAPS(16'hB400), .DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .seed_load (seed_load),
    .seed      (seed),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef LFSR_CIPHER_BYPASS_EN
    .bypass    (1'b0),
`endif
    .out_data  (out_data)
  );
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [15:0] s);
    seed      = s;
    seed_load = 1;
    tick();
    seed_load = 0;
  endtask
  task automatic wait_rdy(output int n);
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
  endtask
  task automatic xfer(input string tag, input logic [7:0] d, input logic [7:0] exp, input bit drain);
    int n;
    wait_rdy(n);
    in_valid = 1;
    in_data  = d;
    tick();
    in_valid = 0;
    check({tag, "_ov"}, 16'(out_valid), 16'd1);
    check({tag, "_ir"}, 16'(in_ready), 16'd0);
    check({tag, "_data"}, 16'(out_data), 16'(exp));
    if (drain) begin
      out_ready = 1;
      tick();
      out_ready = 0;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int   n;
    logic ok;
    tick();
    tick();
    reset = 1;
    ok = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (in_ready || out_valid) ok = 0;
    end
    check("unseeded_idle", 16'(ok), 16'd1);
    check("reset_data", 16'(out_data), 16'h0);
    load(16'hACE1);
    wait_rdy(n);
    check("seed_lat", 16'(n), 16'd8);
    xfer("w0", 8'h00, 8'hAC, 1);
    check("drain_ov", 16'(out_valid), 16'd0);
    wait_rdy(n);
    check("next_lat", 16'(n), 16'd8);
    xfer("w1", 8'h00, 8'hE1, 1);
    load(16'hACE1);
    xfer("enc", 8'h5A, 8'hF6, 1);
    load(16'hACE1);
    xfer("dec", 8'hF6, 8'h5A, 1);
    load(16'hACE1);
    xfer("stall", 8'h00, 8'hAC, 0);
    ok = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!out_valid || out_data !== 8'hAC || in_ready) ok = 0;
    end
    check("stall_hold", 16'(ok), 16'd1);
    out_ready = 1;
    tick();
    out_ready = 0;
    wait_rdy(n);
    check("stall_lat", 16'(n), 16'd8);
    xfer("after_stall", 8'h00, 8'hE1, 1);
    load(16'h0000);
    xfer("zero_seed0", 8'h3C, 8'h3C, 1);
    xfer("zero_seed1", 8'h00, 8'h01, 1);
    load(16'hACE1);
    xfer("pend", 8'h00, 8'hAC, 0);
    load(16'h1234);
    check("drop_ov", 16'(out_valid), 16'd0);
    wait_rdy(n);
    check("reseed_lat", 16'(n), 16'd8);
    xfer("restart", 8'h00, 8'h12, 1);
    load(16'hACE1);
    tick();
    tick();
    tick();
    en = 0;
    ok = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (in_ready) ok = 0;
    end
    check("en_freeze_ir", 16'(ok), 16'd1);
    en = 1;
    wait_rdy(n);
    check("en_lat", 16'(n + 6), 16'd11);
    en = 0;
    #1;
    check("en_gate_ir", 16'(in_ready), 16'd0);
    en = 1;
    xfer("en_key", 8'h00, 8'hAC, 0);
    en = 0;
    out_ready = 1;
    tick();
    check("en_hold_ov", 16'(out_valid), 16'd1);
    en = 1;
    tick();
    out_ready = 0;
    check("en_drain_ov", 16'(out_valid), 16'd0);
    load(16'hACE1);
    tick();
    tick();
    tick();
    reset = 0;
    tick();
    reset = 1;
    check("rst_ir", 16'(in_ready), 16'd0);
    check("rst_ov", 16'(out_valid), 16'd0);
    check("rst_data", 16'(out_data), 16'h0);
    ok = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (in_ready || out_valid) ok = 0;
    end
    check("rst_unseeded", 16'(ok), 16'd1);
    load(16'hACE1);
    xfer("post_rst", 8'h00, 8'hAC, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
